// File: rtl/uc_pkg.sv
// Shared definitions for the fetch stage.
// Widths, instruction size and fetch FSM encoding.
package uc_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int DATA_WIDTH  = 8;
  localparam int INSTR_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    REQ_HI = 2'd0,
    CAP_HI = 2'd1,
    CAP_LO = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

  // States that issue a memory read and bump the PC.
  function automatic logic is_read(fetch_state_t s);
    return (s == REQ_HI) || (s == CAP_HI);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC link, program memory and decode handshake.
// master = fetch stage, slave = PC/memory/decode side.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = uc_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = uc_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]   pc_addr;
  logic                    pc_inc;
  logic                    flush;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_rd;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [2*DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]   instr_pc;
  logic                    instr_valid;
  logic                    instr_ready;

  modport master (
    input  pc_addr,
    input  flush,
    input  mem_rdata,
    input  instr_ready,
    output pc_inc,
    output mem_addr,
    output mem_rd,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output pc_addr,
    output flush,
    output mem_rdata,
    output instr_ready,
    input  pc_inc,
    input  mem_addr,
    input  mem_rd,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads two bytes per instruction (high first)
// and presents {hi, lo} to decode over valid/ready.
module instruction_fetch #(
  parameter int ADDR_WIDTH = uc_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = uc_pkg::DATA_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clk_valid,
  instruction_fetch_if.master bus
);

  import uc_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] ipc;
  logic                  valid;
  logic                  read_req;

  // A read (and PC bump) only in an enabled, unflushed cycle.
  assign read_req = clk_valid & ~rst & ~bus.flush
                  & is_read(state);

  assign bus.mem_addr    = bus.pc_addr;
  assign bus.mem_rd      = read_req;
  assign bus.pc_inc      = read_req;
  assign bus.instr       = {hi, lo};
  assign bus.instr_pc    = ipc;
  assign bus.instr_valid = valid;

  // State register; frozen while the clock enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ_HI;
    end else if (clk_valid) begin
      state <= state_next;
    end
  end

  // Next state; flush beats an accepting handshake.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = REQ_HI;
    end else begin
      unique case (state)
        REQ_HI: state_next = CAP_HI;
        CAP_HI: state_next = CAP_LO;
        CAP_LO: state_next = HOLD;
        HOLD: begin
          if (valid && bus.instr_ready) begin
            state_next = REQ_HI;
          end
        end
      endcase
    end
  end

  // Byte capture, instruction address and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      ipc   <= '0;
      valid <= 1'b0;
    end else if (clk_valid) begin
      if (bus.flush) begin
        valid <= 1'b0;
      end else begin
        unique case (state)
          REQ_HI: ipc <= bus.pc_addr;
          CAP_HI: hi  <= bus.mem_rdata;
          CAP_LO: begin
            lo    <= bus.mem_rdata;
            valid <= 1'b1;
          end
          HOLD: begin
            if (bus.instr_ready) begin
              valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with PC and memory models,
// directed vectors, corner sequences and a random scoreboard.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst;
  logic clk_valid;
  logic flush;
  logic ready;
  logic [11:0] pc_next;
  logic [11:0] pc;
  logic        preset_en;
  logic [11:0] preset_val;
  logic [7:0]  mem [0:4095];
  logic [7:0]  rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .clk_valid (clk_valid),
    .bus       (bus)
  );

  assign bus.pc_addr     = pc;
  assign bus.mem_rdata   = rdata;
  assign bus.flush       = flush;
  assign bus.instr_ready = ready;

  // Program counter and 1-cycle synchronous program memory.
  always @(posedge clk) begin
    if (preset_en) pc <= preset_val;
    else if (clk_valid) begin
      if (flush) pc <= pc_next;
      else if (bus.pc_inc) pc <= pc + 12'd1;
    end
    if (clk_valid && bus.mem_rd) rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [11:0] a);
    logic [11:0] a1;
    a1 = a + 12'd1;
    return {mem[a], mem[a1]};
  endfunction

  // One cycle: drive before the edge, settle, check gating.
  task automatic step(input logic cv, input logic rdy,
                      input logic fl, input logic [11:0] pn);
    @(negedge clk);
    rst = 1'b0;
    clk_valid = cv;
    ready = rdy;
    flush = fl;
    pc_next = pn;
    #1;
    if (!cv || fl) begin
      chk("gate_pc_inc", 32'(bus.pc_inc), 32'd0);
      chk("gate_mem_rd", 32'(bus.mem_rd), 32'd0);
    end
  endtask

  task automatic do_reset(input logic [11:0] start);
    @(negedge clk);
    rst = 1'b1;
    clk_valid = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    pc_next = '0;
    preset_en = 1'b1;
    preset_val = start;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc_inc", 32'(bus.pc_inc), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    preset_en = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        inc;
    logic [11:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic [11:0] ipc;
  } vec_t;

  vec_t tv [14];

  initial begin
    int k;
    int incs;
    int n_acc;
    logic [11:0] exp_addr;
    logic [11:0] start;
    logic cv, rdy, fl, hold_exp;
    logic [11:0] pn;
    logic [1:0] pat [4];

    rst = 1'b1;
    clk_valid = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    pc_next = '0;
    preset_en = 1'b0;
    preset_val = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h000] = 8'hA5;
    mem[12'h001] = 8'h3C;
    mem[12'h002] = 8'h5A;
    mem[12'h003] = 8'hC3;
    mem[12'h1F0] = 8'hDE;
    mem[12'h1F1] = 8'hAD;
    mem[12'h300] = 8'h77;
    mem[12'h301] = 8'h88;
    mem[12'hFFF] = 8'h12;

    tv[0]  = '{1'b1, 1'b1, 12'h000, 1'b0, 16'h0, 12'h0};
    tv[1]  = '{1'b1, 1'b1, 12'h001, 1'b0, 16'h0, 12'h0};
    tv[2]  = '{1'b1, 1'b0, 12'h002, 1'b0, 16'h0, 12'h0};
    tv[3]  = '{1'b1, 1'b0, 12'h002, 1'b1, 16'hA53C, 12'h0};
    tv[4]  = '{1'b0, 1'b1, 12'h002, 1'b0, 16'h0, 12'h0};
    tv[5]  = '{1'b0, 1'b1, 12'h003, 1'b0, 16'h0, 12'h0};
    tv[6]  = '{1'b0, 1'b0, 12'h004, 1'b0, 16'h0, 12'h0};
    for (int i = 7; i < 12; i++)
      tv[i] = '{1'b0, 1'b0, 12'h004, 1'b1, 16'h5AC3, 12'h2};
    tv[12] = '{1'b1, 1'b0, 12'h004, 1'b1, 16'h5AC3, 12'h2};
    tv[13] = '{1'b0, 1'b1, 12'h004, 1'b0, 16'h0, 12'h0};

    // Directed vectors from reset: two fetches, one stalled.
    do_reset(12'h000);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tv[i].rdy, 1'b0, 12'h0);
      chk($sformatf("tv%0d_pc_inc", i),
          32'(bus.pc_inc), 32'(tv[i].inc));
      chk($sformatf("tv%0d_mem_rd", i),
          32'(bus.mem_rd), 32'(tv[i].inc));
      chk($sformatf("tv%0d_mem_addr", i),
          32'(bus.mem_addr), 32'(tv[i].addr));
      chk($sformatf("tv%0d_valid", i),
          32'(bus.instr_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("tv%0d_instr", i),
            32'(bus.instr), 32'(tv[i].ins));
        chk($sformatf("tv%0d_instr_pc", i),
            32'(bus.instr_pc), 32'(tv[i].ipc));
      end
    end

    // Flush during CAP_HI redirects to 0x1F0.
    do_reset(12'h000);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b1, 12'h1F0);
    k = 0;
    while (k < 10) begin
      step(1'b1, 1'b0, 1'b0, 12'h0);
      if (bus.instr_valid) break;
      k++;
    end
    chk("flush_latency", 32'(k), 32'd3);
    chk("flush_instr_pc", 32'(bus.instr_pc), 32'h1F0);
    chk("flush_instr", 32'(bus.instr), 32'hDEAD);

    // Flush and handshake together in HOLD.
    step(1'b1, 1'b1, 1'b1, 12'h300);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("fh_valid", 32'(bus.instr_valid), 32'd0);
    chk("fh_req_inc", 32'(bus.pc_inc), 32'd1);
    chk("fh_req_addr", 32'(bus.mem_addr), 32'h300);
    k = 0;
    while (k < 10) begin
      step(1'b1, 1'b0, 1'b0, 12'h0);
      if (bus.instr_valid) break;
      k++;
    end
    chk("fh_latency", 32'(k), 32'd2);
    chk("fh_instr_pc", 32'(bus.instr_pc), 32'h300);
    chk("fh_instr", 32'(bus.instr), 32'h7788);
    chk("fh_pc_after", 32'(pc), 32'h302);

    // Clock enable toggled 1,0,0,1 during a fetch.
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
    do_reset(12'h000);
    incs = 0;
    k = 0;
    while (k < 60) begin
      step(pat[k % 4][0], 1'b0, 1'b0, 12'h0);
      if (bus.pc_inc) incs++;
      if (bus.instr_valid) break;
      k++;
    end
    chk("cv_found", 32'(bus.instr_valid), 32'd1);
    chk("cv_instr", 32'(bus.instr), 32'hA53C);
    chk("cv_instr_pc", 32'(bus.instr_pc), 32'h0);
    chk("cv_incs", 32'(incs), 32'd2);
    chk("cv_pc", 32'(pc), 32'h2);

    // Wrap: high byte at 0xFFF, low byte at 0x000.
    mem[12'h000] = 8'h34;
    do_reset(12'hFFF);
    k = 0;
    while (k < 10) begin
      step(1'b1, 1'b0, 1'b0, 12'h0);
      if (bus.instr_valid) break;
      k++;
    end
    chk("wrap_instr", 32'(bus.instr), 32'h1234);
    chk("wrap_instr_pc", 32'(bus.instr_pc), 32'hFFF);
    chk("wrap_pc", 32'(pc), 32'h001);

    // Reset asserted during CAP_LO.
    do_reset(12'h100);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_inc", 32'(bus.pc_inc), 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("rst_mid_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_mid_req", 32'(bus.mem_rd), 32'd1);
    chk("rst_mid_ipc", 32'(bus.instr_pc), 32'd0);

    // Random run against a transaction-level scoreboard.
    start = 12'($urandom);
    do_reset(start);
    exp_addr = start;
    n_acc = 0;
    hold_exp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cv  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 19) == 0);
      pn  = 12'($urandom);
      step(cv, rdy, fl, pn);
      if (hold_exp)
        chk("rnd_valid_hold", 32'(bus.instr_valid), 32'd1);
      if (cv && !fl && rdy && bus.instr_valid) begin
        chk("rnd_instr_pc", 32'(bus.instr_pc), 32'(exp_addr));
        chk("rnd_instr", 32'(bus.instr),
            32'(word_at(exp_addr)));
        chk("rnd_pc_incs", 32'(pc), 32'(exp_addr + 12'd2));
        exp_addr = exp_addr + 12'd2;
        n_acc++;
      end
      if (cv && fl) exp_addr = pn;
      hold_exp = bus.instr_valid && !(cv && (fl || rdy));
    end
    chk("rnd_accepts", 32'(n_acc > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
